// File: rtl/cmdmem_arbiter.sv
// Command-RAM arbiter: the slow-clock loader fills the RAM while the HERA core is held
// in reset, then the core fetches from the RAM once a handoff delay has elapsed.
module cmdmem_arbiter #(
  parameter int HANDOFF_CYCLES = 16
) (
  input  logic        clk_48,
  input  logic        rst_,
  input  logic        ld_wren,
  input  logic [9:0]  ld_addr,
  input  logic [15:0] ld_data,
  input  logic        ld_resout,
  input  logic        cpu_req,
  input  logic [9:0]  cpu_addr,
  output logic [15:0] cpu_rdata,
  output logic        cpu_valid,
  output logic        cpu_rst_,
  output logic [9:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_wren,
  input  logic [15:0] mem_rdata,
  output logic [1:0]  state,
  output logic [10:0] wr_count
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD    = 2'd1;
  localparam logic [1:0] HANDOFF = 2'd2;
  localparam logic [1:0] RUN     = 2'd3;

  localparam int          CW     = (HANDOFF_CYCLES > 1) ? $clog2(HANDOFF_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(HANDOFF_CYCLES - 1);
  localparam logic [10:0] WR_MAX = 11'd1024;
  localparam int          SYNC   = 3;

  // Two synchronizer flops plus one history flop for edge detection.
  logic [SYNC-1:0] wren_pipe_q, resout_pipe_q;
  logic [1:0]      prime_q;
  logic            armed_q;
  logic            wr_pulse, end_pulse;

  always_ff @(posedge clk_48 or negedge rst_) begin
    if (!rst_) begin
      wren_pipe_q   <= '0;
      resout_pipe_q <= '1;
      prime_q       <= '0;
      armed_q       <= 1'b0;
    end else begin
      wren_pipe_q   <= {wren_pipe_q[SYNC-2:0], ld_wren};
      resout_pipe_q <= {resout_pipe_q[SYNC-2:0], ld_resout};
      prime_q       <= {prime_q[0], 1'b1};
      // A write held across reset must not fire: arm only after a genuine low sample.
      if (prime_q[1] && !wren_pipe_q[1]) armed_q <= 1'b1;
    end
  end

  assign wr_pulse  = armed_q & wren_pipe_q[1] & ~wren_pipe_q[2];
  assign end_pulse = ~resout_pipe_q[1] & resout_pipe_q[2];

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [10:0]   wr_count_q, wr_count_d, wr_inc;
  logic          cpu_rst_q, cpu_valid_q, mem_wren_q;
  logic [9:0]    mem_addr_q;
  logic [15:0]   mem_wdata_q;

  assign wr_inc = (wr_count_q == WR_MAX) ? WR_MAX : wr_count_q + 11'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_count_d = wr_count_q;
    case (state_q)
      IDLE: begin
        if (wr_pulse) begin
          state_d    = LOAD;
          wr_count_d = 11'd1;
        end else if (end_pulse) begin
          state_d    = HANDOFF;
          wr_count_d = '0;
          cnt_d      = CNT_LOAD;
        end
      end
      LOAD: begin
        if (wr_pulse) begin
          wr_count_d = wr_inc;
        end else if (end_pulse) begin
          state_d = HANDOFF;
          cnt_d   = CNT_LOAD;
        end
      end
      HANDOFF: begin
        if (wr_pulse) begin
          state_d    = LOAD;
          wr_count_d = wr_inc;
        end else if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        if (wr_pulse) begin
          state_d    = LOAD;
          wr_count_d = 11'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_48 or negedge rst_) begin
    if (!rst_) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_count_q  <= '0;
      cpu_rst_q   <= 1'b0;
      cpu_valid_q <= 1'b0;
      mem_wren_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_count_q  <= wr_count_d;
      cpu_rst_q   <= (state_d == RUN);
      // A loader write in RUN pre-empts the fetch issued in the same cycle.
      cpu_valid_q <= (state_q == RUN) & cpu_req & ~wr_pulse;
      mem_wren_q  <= wr_pulse;
      if (wr_pulse) begin
        mem_addr_q  <= ld_addr;
        mem_wdata_q <= ld_data;
      end
    end
  end

  assign mem_addr  = (state_q == RUN && cpu_req) ? cpu_addr : mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wren  = mem_wren_q;
  assign cpu_rdata = mem_rdata;
  assign cpu_valid = cpu_valid_q;
  assign cpu_rst_  = cpu_rst_q;
  assign state     = state_q;
  assign wr_count  = wr_count_q;
endmodule

// File: tb/tb_cmdmem_arbiter.sv
// Directed bench for cmdmem_arbiter with a behavioural one-cycle-latency command RAM.
module tb_cmdmem_arbiter;
  localparam int H = 16;

  logic        clk_48 = 1'b0;
  logic        rst_;
  logic        ld_wren, ld_resout, cpu_req;
  logic [9:0]  ld_addr, cpu_addr, mem_addr;
  logic [15:0] ld_data, cpu_rdata, mem_wdata, mem_rdata;
  logic        cpu_valid, cpu_rst_, mem_wren;
  logic [1:0]  state;
  logic [10:0] wr_count;

  cmdmem_arbiter #(.HANDOFF_CYCLES(H)) dut (
    .clk_48(clk_48), .rst_(rst_), .ld_wren(ld_wren), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_resout(ld_resout), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata),
    .cpu_valid(cpu_valid), .cpu_rst_(cpu_rst_), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wren(mem_wren), .mem_rdata(mem_rdata), .state(state), .wr_count(wr_count)
  );

  always #5 clk_48 = ~clk_48;

  logic [15:0] ram [1024];
  always @(posedge clk_48) begin
    if (mem_wren) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int wren_cnt = 0;
  int viol = 0;
  always @(negedge clk_48) begin
    if (mem_wren === 1'b1) wren_cnt++;
    if (mem_wren === 1'b1 && state == 2'd3 && cpu_req) viol++;
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic ld_write(input logic [9:0] a, input logic [15:0] d, input int hi, input int lo);
    @(posedge clk_48); #1;
    ld_addr = a; ld_data = d; ld_wren = 1'b1;
    repeat (hi) @(posedge clk_48);
    #1 ld_wren = 1'b0;
    repeat (lo) @(posedge clk_48);
  endtask

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] data;
    logic [10:0] exp_cnt;
  } vec_t;
  vec_t vecs [3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, base, cpu_low_seen;
    vecs[0] = '{10'h000, 16'h1234, 11'd1};
    vecs[1] = '{10'h001, 16'hABCD, 11'd2};
    vecs[2] = '{10'h002, 16'hEEFF, 11'd3};

    rst_ = 1'b0; ld_wren = 1'b0; ld_resout = 1'b1; cpu_req = 1'b0;
    ld_addr = '0; ld_data = '0; cpu_addr = '0;
    #12;
    chk("rst_state",     32'(state), 32'd0);
    chk("rst_cpu_rst",   32'(cpu_rst_), 32'd0);
    chk("rst_mem_wren",  32'(mem_wren), 32'd0);
    chk("rst_mem_addr",  32'(mem_addr), 32'd0);
    chk("rst_wr_count",  32'(wr_count), 32'd0);
    @(posedge clk_48); #1 rst_ = 1'b1;
    repeat (5) @(posedge clk_48);

    // Load three words.
    for (int i = 0; i < 3; i++) begin
      ld_write(vecs[i].addr, vecs[i].data, 4, 4);
      @(negedge clk_48);
      chk("load_state", 32'(state), 32'd1);
      chk("load_count", 32'(wr_count), 32'(vecs[i].exp_cnt));
      chk("load_ram",   32'(ram[vecs[i].addr]), 32'(vecs[i].data));
    end
    chk("load_pulses", 32'(wren_cnt), 32'd3);

    // End of load: 2 sync flops + state register + H handoff cycles.
    @(posedge clk_48); #1 ld_resout = 1'b0;
    n = 0;
    cpu_low_seen = 0;
    while (n < 100) begin
      @(posedge clk_48); n++;
      @(negedge clk_48);
      if (n == 4) chk("handoff_state", 32'(state), 32'd2);
      if (cpu_rst_) break;
    end
    chk("release_delay", 32'(n), 32'(H + 3));
    chk("run_state", 32'(state), 32'd3);
    chk("run_count", 32'(wr_count), 32'd3);

    // Fetch address 1 four times.
    @(posedge clk_48); #1 cpu_req = 1'b1; cpu_addr = 10'h001; ld_resout = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_48);
      chk("fetch_valid", 32'(cpu_valid), 32'((c >= 2 && c <= 5) ? 1 : 0));
      if (c <= 4) chk("fetch_addr", 32'(mem_addr), 32'h001);
      if (c >= 2 && c <= 5) chk("fetch_data", 32'(cpu_rdata), 32'hABCD);
      @(posedge clk_48); #1;
      if (c == 4) cpu_req = 1'b0;
    end

    // Loader write collides with a fetch in RUN.
    cpu_req = 1'b1; cpu_addr = 10'h002;
    repeat (2) @(posedge clk_48);
    #1 ld_addr = 10'h005; ld_data = 16'h5555; ld_wren = 1'b1;
    base = wren_cnt;
    repeat (2) @(posedge clk_48);
    @(negedge clk_48);
    chk("pre_conflict_state", 32'(state), 32'd3);
    chk("pre_conflict_valid", 32'(cpu_valid), 32'd1);
    @(posedge clk_48);
    @(negedge clk_48);
    chk("conflict_state",   32'(state), 32'd1);
    chk("conflict_cpu_rst", 32'(cpu_rst_), 32'd0);
    chk("conflict_valid",   32'(cpu_valid), 32'd0);
    chk("conflict_wren",    32'(mem_wren), 32'd1);
    chk("conflict_count",   32'(wr_count), 32'd1);
    chk("conflict_addr",    32'(mem_addr), 32'h005);
    repeat (2) @(posedge clk_48);
    #1 ld_wren = 1'b0; cpu_req = 1'b0;
    repeat (4) @(posedge clk_48);
    chk("conflict_pulses", 32'(wren_cnt), 32'(base + 1));
    chk("conflict_ram",    32'(ram[5]), 32'h5555);

    // Loader restarts in the fifth handoff cycle.
    @(posedge clk_48); #1 ld_resout = 1'b0;
    repeat (3) @(posedge clk_48);
    @(negedge clk_48);
    chk("handoff2_state", 32'(state), 32'd2);
    repeat (4) @(posedge clk_48);
    #1 ld_addr = 10'h007; ld_data = 16'h7777; ld_wren = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_48);
      if (cpu_rst_) cpu_low_seen++;
    end
    chk("handoff2_cpu_rst_high_cycles", 32'(cpu_low_seen), 32'd0);
    chk("handoff2_state_load", 32'(state), 32'd1);
    chk("handoff2_count", 32'(wr_count), 32'd2);
    #1 ld_wren = 1'b0; ld_resout = 1'b1;
    repeat (4) @(posedge clk_48);

    // Saturation: 1030 more writes starting from wr_count=2.
    base = wren_cnt;
    for (int i = 0; i < 1030; i++) begin
      ld_write(10'(i), 16'(i) + 16'h0100, 3, 3);
      if (i == 1020) begin
        @(negedge clk_48); chk("sat_1023", 32'(wr_count), 32'd1023);
      end
      if (i == 1021) begin
        @(negedge clk_48); chk("sat_1024", 32'(wr_count), 32'd1024);
      end
    end
    @(negedge clk_48);
    chk("sat_hold",   32'(wr_count), 32'd1024);
    chk("sat_state",  32'(state), 32'd1);
    chk("sat_pulses", 32'(wren_cnt), 32'(base + 1030));
    chk("sat_wrap_ram", 32'(ram[5]), 32'(16'd1029 + 16'h0100));

    // Reset in the middle of a pending write.
    @(posedge clk_48); #1 ld_addr = 10'h009; ld_data = 16'h9999; ld_wren = 1'b1;
    repeat (2) @(posedge clk_48);
    #1 rst_ = 1'b0;
    #1;
    chk("mid_rst_state",     32'(state), 32'd0);
    chk("mid_rst_cpu_rst",   32'(cpu_rst_), 32'd0);
    chk("mid_rst_valid",     32'(cpu_valid), 32'd0);
    chk("mid_rst_wren",      32'(mem_wren), 32'd0);
    chk("mid_rst_addr",      32'(mem_addr), 32'd0);
    chk("mid_rst_wdata",     32'(mem_wdata), 32'd0);
    chk("mid_rst_count",     32'(wr_count), 32'd0);
    base = wren_cnt;
    repeat (3) @(posedge clk_48);
    #1 rst_ = 1'b1;
    repeat (12) @(posedge clk_48);
    chk("post_rst_no_write", 32'(wren_cnt), 32'(base));
    chk("post_rst_state",    32'(state), 32'd0);
    #1 ld_wren = 1'b0;
    repeat (4) @(posedge clk_48);
    #1 ld_wren = 1'b1;
    repeat (4) @(posedge clk_48);
    @(negedge clk_48);
    chk("new_edge_state", 32'(state), 32'd1);
    chk("new_edge_count", 32'(wr_count), 32'd1);
    chk("new_edge_ram",   32'(ram[9]), 32'h9999);
    #1 ld_wren = 1'b0;
    repeat (2) @(posedge clk_48);

    chk("no_write_during_fetch", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
